// File: rtl/mem_dump_pkg.sv
// Shared memory-protocol constants for the drain engine and its buffer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mem_dump_pkg;

    localparam int memory_addr_width = 10;
    localparam int memory_data_width = 64;

    // memory_unit function encodings
    localparam logic [1:0] MEM_READ  = 2'b00;
    localparam logic [1:0] MEM_WRITE = 2'b01;

endpackage

// File: rtl/dump_fifo2.sv
// Two-entry synchronous FIFO holding {addr, data} words for the dump stream.
// Latency: push visible at head the cycle after the push.
// Backpressure: push ignored when full unless a pop happens the same cycle.
//
// Ports: clk, rst_n (async active-low); push/push_dat write side;
//        pop read side; head_dat is the oldest entry; full/empty/count status.
module dump_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] slot [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;
    logic         do_push;
    logic         do_pop;

    assign empty    = (cnt == 2'd0);
    assign full     = (cnt == 2'd2);
    assign count    = cnt;
    assign head_dat = slot[rd_ptr];

    assign do_pop  = pop && !empty;
    // When full, a simultaneous pop frees the slot being written.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            cnt     <= 2'd0;
        end else begin
            if (do_push) begin
                slot[wr_ptr] <= push_dat;
                wr_ptr       <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mem_dump.sv
// Drains a contiguous memory range through a read-only memory port onto a valid/ready stream.
// Latency: start->first strobe 2 cycles; capture->out_valid 1 cycle; done 1 cycle after last handshake.
// Backpressure: 2-entry buffer; no new read is issued while the buffer is full.
//
// Ports: clk, rst_n (async active-low); start/base_addr/length command, busy/done status;
//        mem_ready/mem_execute/mem_func/address/read_data memory initiator;
//        out_valid/out_ready/out_data/out_addr output stream.
module mem_dump
    import mem_dump_pkg::*;
#(
    parameter int ADDR_W    = memory_addr_width,
    parameter int DATA_W    = memory_data_width,
    parameter int MAX_LEN_W = ADDR_W + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [MAX_LEN_W-1:0] length,
    output logic                 busy,
    output logic                 done,
    input  logic                 mem_ready,
    output logic                 mem_execute,
    output logic [1:0]           mem_func,
    output logic [ADDR_W-1:0]    address,
    input  logic [DATA_W-1:0]    read_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [ADDR_W-1:0]    out_addr
);

    localparam int ENTRY_W = ADDR_W + DATA_W;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic [ADDR_W-1:0]    cur;
    logic [MAX_LEN_W-1:0] left;
    logic                 busy_q;
    logic                 done_q;
    logic                 exec_q;
    logic [ADDR_W-1:0]    addr_q;

    logic                 accept;
    logic                 capture;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [1:0]           fifo_count;
    logic [ENTRY_W-1:0]   head;

    // FINISH is the done cycle; a start there is taken just like in IDLE.
    assign accept = start && ((state == S_IDLE) || (state == S_FINISH));

    // The memory still shows the stale mem_ready=1 during the strobe cycle,
    // so the return edge is only trusted once the strobe has gone.
    assign capture = (state == S_WAIT) && mem_ready && !exec_q;

    assign pop = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_FINISH: begin
                state_nxt = S_IDLE;
                // Zero length passes through DRAIN with an empty buffer, giving
                // one busy cycle before the done cycle.
                if (accept) begin
                    state_nxt = (length == '0) ? S_DRAIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Reads are strictly one at a time, so here nothing is in
                // flight and a non-full buffer guarantees room for the reply.
                if (mem_ready && !fifo_full) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (capture) begin
                    state_nxt = (left == MAX_LEN_W'(1)) ? S_DRAIN : S_ISSUE;
                end
            end
            S_DRAIN: begin
                // Leave as the last word is popped so done lands one cycle later.
                if (fifo_empty || ((fifo_count == 2'd1) && pop)) begin
                    state_nxt = S_FINISH;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cur    <= '0;
            left   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            exec_q <= 1'b0;
            addr_q <= '0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt == S_ISSUE) || (state_nxt == S_WAIT) || (state_nxt == S_DRAIN);
            done_q <= (state_nxt == S_FINISH);
            exec_q <= (state == S_ISSUE) && (state_nxt == S_WAIT);
            if ((state == S_ISSUE) && (state_nxt == S_WAIT)) begin
                addr_q <= cur;
            end
            if (accept) begin
                cur  <= base_addr;
                left <= length;
            end else if (capture) begin
                cur  <= cur + ADDR_W'(1);
                left <= left - MAX_LEN_W'(1);
            end
        end
    end

    dump_fifo2 #(
        .W (ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (capture),
        .push_dat ({cur, read_data}),
        .pop      (pop),
        .head_dat (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_execute = exec_q;
    assign mem_func    = MEM_READ;
    assign address     = addr_q;
    assign out_valid   = !fifo_empty;
    assign out_addr    = head[ENTRY_W-1:DATA_W];
    assign out_data    = head[DATA_W-1:0];

endmodule

// File: tb/tb_mem_dump.sv
// Directed bench for mem_dump with a fixed-latency memory model and stream monitor.
// Latency: memory replies LAT cycles after accepting a strobe.
// Backpressure: out_ready driven per test.
module tb_mem_dump;
    import mem_dump_pkg::*;

    localparam int AW  = 10;
    localparam int DW  = 64;
    localparam int LW  = 11;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] length;
    logic          busy;
    logic          done;
    logic          mem_ready = 1'b1;
    logic          mem_execute;
    logic [1:0]    mem_func;
    logic [AW-1:0] address;
    logic [DW-1:0] read_data = '0;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;

    always #5 clk = ~clk;

    mem_dump #(.ADDR_W(AW), .DATA_W(DW), .MAX_LEN_W(LW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .length      (length),
        .busy        (busy),
        .done        (done),
        .mem_ready   (mem_ready),
        .mem_execute (mem_execute),
        .mem_func    (mem_func),
        .address     (address),
        .read_data   (read_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_addr    (out_addr)
    );

    // Memory model: not reset by rst_n, so an aborted read still completes.
    logic [DW-1:0] mem [1024];
    int            lat_cnt = 0;
    logic [AW-1:0] pend_addr = '0;

    always @(posedge clk) begin
        if (mem_ready) begin
            if (mem_execute) begin
                mem_ready <= 1'b0;
                lat_cnt   <= LAT;
                pend_addr <= address;
            end
        end else if (lat_cnt == 1) begin
            read_data <= mem[pend_addr];
            mem_ready <= 1'b1;
        end else begin
            lat_cnt <= lat_cnt - 1;
        end
    end

    // Monitor
    int            exec_cnt, done_cnt, valid_seen, func_bad;
    logic [AW-1:0] got_addr [$];
    logic [DW-1:0] got_data [$];

    always @(negedge clk) begin
        if (mem_execute) begin
            exec_cnt++;
            if (mem_func !== MEM_READ) func_bad++;
        end
        if (done) done_cnt++;
        if (out_valid) valid_seen++;
        if (out_valid && out_ready) begin
            got_addr.push_back(out_addr);
            got_data.push_back(out_data);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        exec_cnt   = 0;
        done_cnt   = 0;
        valid_seen = 0;
        func_bad   = 0;
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic pulse_start(input logic [AW-1:0] b, input logic [LW-1:0] l);
        base_addr = b;
        length    = l;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        for (int i = 0; i < 400 && done_cnt < target; i++) tick();
        check(tag, 64'(done_cnt >= target), 64'd1);
        repeat (3) tick();
    endtask

    task automatic check_word(input string tag, input int i, input logic [AW-1:0] ea,
                              input logic [DW-1:0] ed);
        if (i < got_addr.size()) begin
            check({tag, "_addr"}, 64'(got_addr[i]), 64'(ea));
            check({tag, "_data"}, got_data[i], ed);
        end else begin
            check({tag, "_missing"}, 64'(got_addr.size()), 64'(i + 1));
        end
    endtask

    task automatic check_abcd(input string tag);
        check({tag, "_nwords"}, 64'(got_addr.size()), 64'd4);
        check_word({tag, "_w0"}, 0, 10'd1, 64'hA);
        check_word({tag, "_w1"}, 1, 10'd2, 64'hB);
        check_word({tag, "_w2"}, 2, 10'd3, 64'hC);
        check_word({tag, "_w3"}, 3, 10'd4, 64'hD);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 64'h1000 + 64'(i);
        mem[1] = 64'hA;
        mem[2] = 64'hB;
        mem[3] = 64'hC;
        mem[4] = 64'hD;

        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        out_ready = 1'b1;
        clear_mon();
        repeat (3) tick();

        // Reset values
        check("rst_mem_execute", 64'(mem_execute), 64'd0);
        check("rst_mem_func",    64'(mem_func),    64'd0);
        check("rst_address",     64'(address),     64'd0);
        check("rst_out_valid",   64'(out_valid),   64'd0);
        check("rst_out_data",    out_data,         64'd0);
        check("rst_out_addr",    64'(out_addr),    64'd0);
        check("rst_busy",        64'(busy),        64'd0);
        check("rst_done",        64'(done),        64'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Basic dump of cells 1..4 with a free-running consumer
        clear_mon();
        pulse_start(10'd1, 11'd4);
        check("t1_busy_c1", 64'(busy), 64'd1);
        check("t1_exec_c1", 64'(mem_execute), 64'd0);
        tick();
        check("t1_exec_c2", 64'(mem_execute), 64'd1);
        check("t1_addr_c2", 64'(address), 64'd1);
        wait_done(1, "t1_done_seen");
        check_abcd("t1");
        check("t1_exec_cnt", 64'(exec_cnt), 64'd4);
        check("t1_func_bad", 64'(func_bad), 64'd0);
        check("t1_done_cnt", 64'(done_cnt), 64'd1);
        check("t1_busy_end", 64'(busy), 64'd0);

        // Zero length: busy one cycle, done the next, no memory traffic
        clear_mon();
        pulse_start(10'd5, 11'd0);
        check("t2_busy_c1", 64'(busy), 64'd1);
        check("t2_done_c1", 64'(done), 64'd0);
        tick();
        check("t2_done_c2", 64'(done), 64'd1);
        check("t2_busy_c2", 64'(busy), 64'd0);
        tick();
        check("t2_done_c3", 64'(done), 64'd0);
        repeat (5) tick();
        check("t2_exec_cnt", 64'(exec_cnt), 64'd0);
        check("t2_valid_seen", 64'(valid_seen), 64'd0);

        // Stalled consumer: two reads fill the buffer, then nothing more
        clear_mon();
        out_ready = 1'b0;
        pulse_start(10'd1, 11'd4);
        repeat (20) tick();
        check("t3_exec_stall", 64'(exec_cnt), 64'd2);
        check("t3_words_stall", 64'(got_addr.size()), 64'd0);
        check("t3_valid_stall", 64'(out_valid), 64'd1);
        check("t3_head_addr", 64'(out_addr), 64'd1);
        out_ready = 1'b1;
        wait_done(1, "t3_done_seen");
        check_abcd("t3");
        check("t3_exec_cnt", 64'(exec_cnt), 64'd4);

        // Address wrap past the top of memory
        clear_mon();
        pulse_start(10'd1022, 11'd3);
        wait_done(1, "t4_done_seen");
        check("t4_nwords", 64'(got_addr.size()), 64'd3);
        check_word("t4_w0", 0, 10'd1022, 64'h13FE);
        check_word("t4_w1", 1, 10'd1023, 64'h13FF);
        check_word("t4_w2", 2, 10'd0,    64'h1000);

        // Reset while a read is outstanding and a word sits in the buffer
        clear_mon();
        out_ready = 1'b0;
        pulse_start(10'd1, 11'd4);
        for (int i = 0; i < 100 && exec_cnt < 2; i++) tick();
        check("t5_second_read", 64'(exec_cnt), 64'd2);
        rst_n = 1'b0;
        tick();
        check("t5_busy_rst", 64'(busy), 64'd0);
        check("t5_valid_rst", 64'(out_valid), 64'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && !mem_ready; i++) tick();
        check("t5_mem_ready", 64'(mem_ready), 64'd1);
        tick();
        clear_mon();
        pulse_start(10'd2, 11'd1);
        wait_done(1, "t5_done_seen");
        repeat (10) tick();
        check("t5_nwords", 64'(got_addr.size()), 64'd1);
        check_word("t5_w0", 0, 10'd2, 64'hB);
        check("t5_exec_cnt", 64'(exec_cnt), 64'd1);

        // Start while busy is ignored
        clear_mon();
        pulse_start(10'd1, 11'd4);
        repeat (2) tick();
        pulse_start(10'd3, 11'd2);
        wait_done(1, "t6_done_seen");
        repeat (30) tick();
        check_abcd("t6");
        check("t6_done_cnt", 64'(done_cnt), 64'd1);
        check("t6_exec_cnt", 64'(exec_cnt), 64'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
